// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - two-requester round-robin arbiter in front of a shared multiplier datapath
// Optional abort of a stalled datapath: define MULT_TIMEOUT_EN.
module mult_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic [WIDTH-1:0]     i_a0,
    input  logic [WIDTH-1:0]     i_b0,
    input  logic [WIDTH-1:0]     i_a1,
    input  logic [WIDTH-1:0]     i_b1,
    input  logic                 i_ack0,
    input  logic                 i_ack1,
    input  logic                 i_mul_done,
    input  logic [2*WIDTH-1:0]   i_mul_product,
    output logic                 o_gnt0,
    output logic                 o_gnt1,
    output logic                 o_rsp_valid0,
    output logic                 o_rsp_valid1,
    output logic [2*WIDTH-1:0]   o_rsp_product,
    output logic                 o_rsp_err,
    output logic                 o_mul_start,
    output logic [WIDTH-1:0]     o_mul_m,
    output logic [WIDTH-1:0]     o_mul_q,
    output logic                 o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_owner;
    logic                 r_last;
    logic                 r_seen_low;
    logic [WIDTH-1:0]     r_mul_m;
    logic [WIDTH-1:0]     r_mul_q;
    logic [2*WIDTH-1:0]   r_rsp_product;
    logic                 w_winner;
    logic                 w_capture;
    logic                 w_ack;
    logic                 w_timeout;

    // r_last resets to 1 so requester 0 wins the first contention.
    assign w_winner  = (i_req0 && i_req1) ? ~r_last : ~i_req0;
    // A done level already high at launch belongs to the previous operation.
    assign w_capture = (r_state == S_WAIT) && i_mul_done && r_seen_low;
    assign w_ack     = r_owner ? i_ack1 : i_ack0;

`ifdef MULT_TIMEOUT_EN
    localparam int                 CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]      TMAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          r_rsp_err;

    assign w_timeout = (r_state == S_WAIT) && !w_capture && (r_cnt == TMAX);
    assign o_rsp_err = r_rsp_err;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == S_LAUNCH)
                r_cnt <= '0;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt + 1'b1;
            if (w_capture)
                r_rsp_err <= 1'b0;
            else if (w_timeout)
                r_rsp_err <= 1'b1;
        end
    end
`else
    // Counter is compiled out; TIMEOUT stays on the interface for build compatibility.
    assign w_timeout = 1'b0 && (TIMEOUT > 0);
    assign o_rsp_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_req0 || i_req1) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (w_capture || w_timeout) w_next = S_RESP;
            S_RESP:   if (w_ack) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_seen_low    <= 1'b0;
            r_mul_m       <= '0;
            r_mul_q       <= '0;
            r_rsp_product <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (i_req0 || i_req1) begin
                    r_owner <= w_winner;
                    r_last  <= w_winner;
                    r_mul_m <= w_winner ? i_a1 : i_a0;
                    r_mul_q <= w_winner ? i_b1 : i_b0;
                end
                S_LAUNCH: r_seen_low <= 1'b0;
                S_WAIT: begin
                    if (!i_mul_done)
                        r_seen_low <= 1'b1;
                    if (w_capture)
                        r_rsp_product <= i_mul_product;
                    else if (w_timeout)
                        r_rsp_product <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_gnt0        = (r_state == S_LAUNCH) && !r_owner;
    assign o_gnt1        = (r_state == S_LAUNCH) &&  r_owner;
    assign o_mul_start   = (r_state == S_LAUNCH);
    assign o_rsp_valid0  = (r_state == S_RESP) && !r_owner;
    assign o_rsp_valid1  = (r_state == S_RESP) &&  r_owner;
    assign o_busy        = (r_state != S_IDLE);
    assign o_mul_m       = r_mul_m;
    assign o_mul_q       = r_mul_q;
    assign o_rsp_product = r_rsp_product;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter
module tb_mult_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, ack0, ack1;
    logic [3:0] a0, b0, a1, b1;
    logic       mul_done;
    logic [7:0] mul_product;
    logic       gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, mul_start, busy;
    logic [7:0] rsp_product;
    logic [3:0] mul_m, mul_q;

    int n_tests = 0;
    int n_fail  = 0;

    mult_arbiter #(.WIDTH(4), .TIMEOUT(16)) dut (
        .i_clock(clk), .i_reset(reset),
        .i_req0(req0), .i_req1(req1),
        .i_a0(a0), .i_b0(b0), .i_a1(a1), .i_b1(b1),
        .i_ack0(ack0), .i_ack1(ack1),
        .i_mul_done(mul_done), .i_mul_product(mul_product),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rsp_valid0(rsp_valid0), .o_rsp_valid1(rsp_valid1),
        .o_rsp_product(rsp_product), .o_rsp_err(rsp_err),
        .o_mul_start(mul_start), .o_mul_m(mul_m), .o_mul_q(mul_q),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Signed multiplier stub: optionally keeps a stale done high for stale_hold cycles after start.
    int               dp_lat     = 4;
    int               stale_hold = 0;
    int               dp_cnt     = 0;
    int               dp_hold    = 0;
    logic signed [7:0] dp_pending;

    always @(negedge clk) begin
        if (mul_start) begin
            dp_pending = $signed(mul_m) * $signed(mul_q);
            dp_cnt     = dp_lat;
            dp_hold    = stale_hold;
            if (dp_hold == 0) mul_done = 1'b0;
        end else if (dp_hold > 0) begin
            dp_hold = dp_hold - 1;
            if (dp_hold == 0) mul_done = 1'b0;
        end else if (dp_cnt > 0) begin
            dp_cnt = dp_cnt - 1;
            if (dp_cnt == 0) begin
                mul_done    = 1'b1;
                mul_product = dp_pending;
            end
        end
    end

    int n_gnt0 = 0, n_start = 0, n_rsp = 0, n_excl = 0;
    always @(negedge clk) begin
        if (gnt0) n_gnt0++;
        if (mul_start) n_start++;
        if (rsp_valid0 || rsp_valid1) n_rsp++;
        if ((gnt0 && gnt1) || (rsp_valid0 && rsp_valid1)) n_excl++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return gnt0;
            1:       return gnt1;
            2:       return rsp_valid0;
            3:       return rsp_valid1;
            default: return gnt0 | gnt1;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int maxc, output int n);
        n = 0;
        while (!sig(sel) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (!sig(sel)) check($sformatf("wait_sel%0d_timeout", sel), 32'd0, 32'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int  n, g0, st, r;
    logic stable;

    initial begin
        reset = 1'b1; req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; mul_done = 0; mul_product = 0;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_rsp_valid", {rsp_valid0, rsp_valid1}, 0);
        check("rst_start", mul_start, 0);
        check("rst_mul_mq", {mul_m, mul_q}, 0);
        check("rst_product", rsp_product, 0);
        check("rst_err", rsp_err, 0);
        reset = 1'b0;
        tick(1);

        // single requester, 10-cycle datapath
        g0 = n_gnt0; st = n_start;
        a0 = 4'd3; b0 = 4'd5; dp_lat = 10; req0 = 1;
        wait_for(0, 5, n);
        req0 = 0;
        check("t1_mul_mq", {mul_m, mul_q}, {4'd3, 4'd5});
        wait_for(2, 40, n);
        check("t1_product", rsp_product, 8'd15);
        check("t1_err", rsp_err, 0);
        check("t1_rsp1", rsp_valid1, 0);
        check("t1_gnt0_once", n_gnt0 - g0, 1);
        check("t1_start_once", n_start - st, 1);
        ack0 = 1; tick(1); ack0 = 0;
        check("t1_idle", busy, 0);

        // contention after reset: requester 0 first
        reset = 1; tick(2); reset = 0;
        dp_lat = 4;
        a0 = 4'd2; b0 = 4'd7; a1 = 4'hD; b1 = 4'd4; req0 = 1; req1 = 1;
        wait_for(4, 5, n);
        check("t2_first_gnt", {gnt0, gnt1}, 2'b10);
        req0 = 0;
        wait_for(2, 30, n);
        check("t2_prod0", rsp_product, 8'd14);
        ack0 = 1; tick(1); ack0 = 0;
        wait_for(1, 5, n);
        check("t2_gnt1", gnt1, 1);
        req1 = 0;
        wait_for(3, 30, n);
        check("t2_prod1", rsp_product, 8'hF4);
        check("t2_rsp0_low", rsp_valid0, 0);
        ack1 = 1; tick(1); ack1 = 0;

        // round robin back to 0, stale done from previous op ignored
        stale_hold = 3;
        a0 = 4'd6; b0 = 4'd3; a1 = 4'hE; b1 = 4'd3; req0 = 1; req1 = 1;
        wait_for(4, 5, n);
        check("t3_rr_gnt", {gnt0, gnt1}, 2'b10);
        req0 = 0;
        wait_for(2, 30, n);
        check("t3_stale_prod0", rsp_product, 8'h12);
        ack0 = 1; tick(1); ack0 = 0;
        wait_for(1, 5, n);
        req1 = 0;
        wait_for(3, 30, n);
        check("t3_stale_prod1", rsp_product, 8'hFA);
        ack1 = 1; tick(1); ack1 = 0;
        stale_hold = 0;

        // ack withheld 20 cycles; non-owner ack ignored; req1 waits
        a0 = 4'd5; b0 = 4'd5; req0 = 1;
        wait_for(0, 5, n);
        req0 = 0;
        wait_for(2, 30, n);
        a1 = 4'd2; b1 = 4'd2; req1 = 1; ack1 = 1;
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            if (!rsp_valid0 || rsp_product !== 8'h19 || gnt1) stable = 0;
            tick(1);
        end
        check("t4_resp_stable", stable, 1);
        ack1 = 0; ack0 = 1; tick(1); ack0 = 0;
        check("t4_idle_gap", {busy, gnt1}, 2'b00);
        tick(1);
        check("t4_gnt1_after", gnt1, 1);
        req1 = 0;
        wait_for(3, 30, n);
        check("t4_prod1", rsp_product, 8'd4);
        ack1 = 1; tick(1); ack1 = 0;

        // reset mid-WAIT drops the transaction
        a0 = 4'd7; b0 = 4'd7; dp_lat = 10; req0 = 1;
        wait_for(0, 5, n);
        req0 = 0;
        tick(3);
        check("t5_busy_wait", busy, 1);
        reset = 1; tick(1); reset = 0;
        check("t5_after_rst", {busy, mul_start, rsp_valid0, rsp_valid1}, 4'b0000);
        check("t5_mul_m_clr", mul_m, 0);
        r = n_rsp;
        tick(12);
        check("t5_no_rsp", n_rsp - r, 0);
        a1 = 4'hF; b1 = 4'hF; dp_lat = 4; req1 = 1;
        wait_for(1, 5, n);
        check("t5_gnt1", gnt1, 1);
        req1 = 0;
        wait_for(3, 30, n);
        check("t5_prod1", rsp_product, 8'd1);
        ack1 = 1; tick(1); ack1 = 0;

`ifdef MULT_TIMEOUT_EN
        // stuck datapath aborts after 16 WAIT cycles
        a0 = 4'd3; b0 = 4'd3; dp_lat = 1000; req0 = 1;
        wait_for(0, 5, n);
        req0 = 0;
        wait_for(2, 40, n);
        check("t6_timeout_cycles", n, 17);
        check("t6_err", rsp_err, 1);
        check("t6_product", rsp_product, 0);
        ack0 = 1; tick(1); ack0 = 0;
        dp_cnt = 0;
`endif

        check("excl_gnt_rsp", n_excl, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; product width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles spent in WAIT before abort (used only with MULT_TIMEOUT_EN).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  request from requester 0/1; level, held until granted.
REQ-006 a0, b0, a1, b1  input  WIDTH each  multiplicand/multiplier of requester 0/1, valid while reqN high.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured in that cycle.
REQ-008 rsp_valid0, rsp_valid1  output  1 each  result valid for requester 0/1.
REQ-009 ack0, ack1  input  1 each  requester accepts result.
REQ-010 rsp_product  output  2*WIDTH  result shared by both requesters; meaningful only while a rsp_validN is high.
REQ-011 rsp_err  output  1  result aborted by timeout; meaningful only while a rsp_validN is high.
REQ-012 mul_start  output  1  start pulse to the shared multiplier datapath.
REQ-013 mul_M, mul_Q  output  WIDTH each  registered operands driven to the datapath.
REQ-014 mul_done  input  1  datapath done level.
REQ-015 mul_product  input  2*WIDTH  datapath product (A:Q), valid when mul_done is high.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT and RESP.
REQ-018 IDLE: if any reqN is high, select a winner, register its operands and owner, and go to LAUNCH; otherwise stay.
REQ-019 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; a single request wins unconditionally.
REQ-020 LAUNCH lasts exactly one cycle: gntN (owner) = 1, mul_start = 1, mul_M/mul_Q hold the captured operands; next state WAIT.
REQ-021 mul_M/mul_Q SHALL stay stable from LAUNCH through the end of WAIT.
REQ-022 WAIT: the product SHALL be captured only on the first cycle with mul_done = 1 after mul_done has been sampled 0 at least once since LAUNCH; a stale done from a previous operation SHALL be ignored.
REQ-023 On capture: rsp_product <= mul_product, rsp_err <= 0, next state RESP.
REQ-024 RESP: rsp_validN (owner only) = 1, rsp_product and rsp_err held; on ackN = 1, go to IDLE next cycle; otherwise stay.
REQ-025 Ack from the non-owner SHALL be ignored; an ack outside RESP SHALL be ignored.
REQ-026 Deassertion of reqN after grant SHALL NOT abort the transaction.
REQ-027 Requests arriving in non-IDLE states SHALL wait; a request is granted no earlier than the cycle after RESP exits, because IDLE lasts at least one cycle.
REQ-028 At most one gnt and one rsp_valid SHALL be high in any cycle.
REQ-029 Minimum latency from request to rsp_valid SHALL be 3 + (datapath cycles) clocks: IDLE, LAUNCH, WAIT (>=1), RESP.

Reset
REQ-030 While reset is high at a rising edge, state <= IDLE, and gnt0/1, rsp_valid0/1, mul_start, rsp_err, busy are 0.
REQ-031 On reset, rsp_product, mul_M and mul_Q SHALL be 0, and the round-robin pointer SHALL make requester 0 win the first contention.
REQ-032 Reset during LAUNCH, WAIT or RESP SHALL drop the transaction silently, with no rsp_valid produced.

Configuration
REQ-033 Macro MULT_TIMEOUT_EN defined: a cycle counter clears on entering WAIT; when it reaches TIMEOUT without capture, the block goes to RESP with rsp_err = 1 and rsp_product = 0.
REQ-034 MULT_TIMEOUT_EN undefined: no counter exists, WAIT lasts until capture indefinitely, and rsp_err is tied to 0.

Verification
REQ-035 req0 only, a0=3, b0=5, datapath completes in 10 cycles -> gnt0 pulses once, mul_start pulses once, rsp_valid0 with rsp_product=15, rsp_err=0; ack0 -> IDLE.
REQ-036 req0 and req1 both high after reset, a0=2,b0=7, a1=-3 (4'b1101),b1=4 -> requester 0 served first (14), then requester 1 (8'hF4); gnt0 precedes gnt1.
REQ-037 mul_done held high from prior op at LAUNCH -> no capture until done goes low then high; product equals the new operation's.
REQ-038 ack0 withheld for 20 cycles in RESP, req1 high -> rsp_valid0 and rsp_product stable throughout, gnt1 absent until one cycle after ack0.
REQ-039 reset asserted mid-WAIT -> next cycle busy=0, mul_start=0, no rsp_valid; following req1 alone is granted normally.
REQ-040 MULT_TIMEOUT_EN, TIMEOUT=16, mul_done stuck 0 -> after 16 WAIT cycles rsp_valid owner=1, rsp_err=1, rsp_product=0.
